// File: rtl/mem_access_seq.sv
// mem_access_seq: Moore sequencer for a single SRAM read or write through the
// external MAR/MDR registers. Drives the MAR/MDR load strobes, the MDR input
// select and the active-low SRAM strobes, with WAIT_CYCLES wait states.
// Outputs are registered from the next-state decode, so they always reflect
// the registered state without any combinational path from the requests.
module mem_access_seq #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic rd_req,
    input  logic wr_req,
    output logic ready,
    output logic done,
    output logic LD_MAR,
    output logic LD_MDR,
    output logic MDR_sel,
    output logic mem_CE,
    output logic mem_OE,
    output logic mem_WE
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Output vector layout: {ready, done, LD_MAR, LD_MDR, MDR_sel, CE, OE, WE}
    localparam logic [7:0] OUTS_IDLE = 8'b1000_0111;

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("mem_access_seq: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MAR_LD  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_WR_REC  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             op_wr_r;
    logic             op_wr_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]       outs_r;
    logic [7:0]       outs_nxt_s;

    // Strobe pattern for each state; the write flag only matters in MAR_LD,
    // where a write also captures the bus data into MDR.
    function automatic logic [7:0] decode_outs(input state_t st, input logic wr);
        logic [7:0] o;
        case (st)
            ST_IDLE:    o = OUTS_IDLE;
            ST_MAR_LD:  o = {3'b001, wr, 1'b0, 3'b111};
            ST_RD_WAIT: o = 8'b0000_0001;
            ST_RD_CAP:  o = 8'b0001_1001;
            ST_WR_WAIT: o = 8'b0000_0010;
            ST_WR_REC:  o = 8'b0000_0011;
            ST_DONE:    o = 8'b0100_0111;
            default:    o = OUTS_IDLE;
        endcase
        return o;
    endfunction

    // Next-state, operation latch and wait-counter logic
    always_comb begin
        state_nxt_s = state_r;
        op_wr_nxt_s = op_wr_r;
        cnt_nxt_s   = CNT_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (rd_req) begin
                    // Read wins when both arrive together; the write is dropped.
                    state_nxt_s = ST_MAR_LD;
                    op_wr_nxt_s = 1'b0;
                end else if (wr_req) begin
                    state_nxt_s = ST_MAR_LD;
                    op_wr_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MAR_LD: begin
                cnt_nxt_s = CNT_LOAD;
                if (op_wr_r) begin
                    state_nxt_s = ST_WR_WAIT;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RD_CAP;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_RD_CAP: begin
                state_nxt_s = ST_DONE;
            end
            ST_WR_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_WR_REC;
                end else begin
                    state_nxt_s = ST_WR_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_WR_REC: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                // Illegal encoding: fall back to IDLE with no operation pending.
                state_nxt_s = ST_IDLE;
                op_wr_nxt_s = 1'b0;
            end
        endcase
        outs_nxt_s = decode_outs(state_nxt_s, op_wr_nxt_s);
    end

    // State, operation type, wait counter and registered output strobes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            op_wr_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            outs_r  <= OUTS_IDLE;
        end else begin
            state_r <= state_nxt_s;
            op_wr_r <= op_wr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            outs_r  <= outs_nxt_s;
        end
    end

    assign ready   = outs_r[7];
    assign done    = outs_r[6];
    assign LD_MAR  = outs_r[5];
    assign LD_MDR  = outs_r[4];
    assign MDR_sel = outs_r[3];
    assign mem_CE  = outs_r[2];
    assign mem_OE  = outs_r[1];
    assign mem_WE  = outs_r[0];

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (WAIT_CYCLES=2 and 15) share one
// stimulus stream. A phase-count model predicts every output each cycle, a
// small MAR/MDR/SRAM environment around the WAIT=2 instance checks data flow.
module tb_mem_access_seq;

    logic clk = 1'b0;
    logic Reset, rd_req, wr_req;
    logic ready_a, done_a, ld_mar_a, ld_mdr_a, mdr_sel_a, ce_a, oe_a, we_a;
    logic ready_b, done_b, ld_mar_b, ld_mdr_b, mdr_sel_b, ce_b, oe_b, we_b;
    logic [7:0] obs_a, obs_b;

    logic [15:0] bus_addr, bus_data, mar, mdr;
    logic [15:0] sram [0:255];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit model_valid = 1'b0;
    int m_busy [2];
    int m_phase [2];
    int m_wr [2];
    int acc_cyc [2];
    int done_cyc [2];
    int done_cnt [2];
    int ld_mdr_cnt_a = 0;
    int we_low_a = 0;
    int snap_done_a, snap_done_b, snap_ldmdr, snap_we;

    mem_access_seq #(.WAIT_CYCLES(2)) dut_a (
        .Clk(clk), .Reset(Reset), .rd_req(rd_req), .wr_req(wr_req),
        .ready(ready_a), .done(done_a), .LD_MAR(ld_mar_a), .LD_MDR(ld_mdr_a),
        .MDR_sel(mdr_sel_a), .mem_CE(ce_a), .mem_OE(oe_a), .mem_WE(we_a));

    mem_access_seq #(.WAIT_CYCLES(15)) dut_b (
        .Clk(clk), .Reset(Reset), .rd_req(rd_req), .wr_req(wr_req),
        .ready(ready_b), .done(done_b), .LD_MAR(ld_mar_b), .LD_MDR(ld_mdr_b),
        .MDR_sel(mdr_sel_b), .mem_CE(ce_b), .mem_OE(oe_b), .mem_WE(we_b));

    assign obs_a = {ready_a, done_a, ld_mar_a, ld_mdr_a, mdr_sel_a, ce_a, oe_a, we_a};
    assign obs_b = {ready_b, done_b, ld_mar_b, ld_mdr_b, mdr_sel_b, ce_b, oe_b, we_b};

    always #5 clk = ~clk;

    function automatic int wv(input int i);
        return (i == 0) ? 2 : 15;
    endfunction

    // Expected {ready,done,LD_MAR,LD_MDR,MDR_sel,CE,OE,WE} from cycles since acceptance
    function automatic logic [7:0] exp_out(input int busy, input int ph, input int wr, input int w);
        logic [7:0] e;
        e = 8'b1000_0111;
        if (busy != 0) begin
            e = 8'b0000_0111;
            if (ph == 1) begin
                e[5] = 1'b1;
                e[4] = (wr != 0);
            end else if (ph <= w + 1) begin
                e[2] = 1'b0;
                if (wr != 0) e[0] = 1'b0;
                else         e[1] = 1'b0;
            end else if (ph == w + 2) begin
                e[2] = 1'b0;
                if (wr == 0) begin
                    e[1] = 1'b0;
                    e[4] = 1'b1;
                    e[3] = 1'b1;
                end
            end else begin
                e[6] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Behavioural model: one access occupies WAIT+4 cycles from acceptance
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_busy[i]  <= 0;
                m_phase[i] <= 0;
            end else if (m_busy[i] == 0) begin
                if (rd_req || wr_req) begin
                    m_busy[i]  <= 1;
                    m_phase[i] <= 1;
                    m_wr[i]    <= rd_req ? 0 : 1;
                    acc_cyc[i] <= cyc;
                end
            end else if (m_phase[i] >= wv(i) + 3) begin
                m_busy[i] <= 0;
            end else begin
                m_phase[i] <= m_phase[i] + 1;
            end
        end
        if (Reset) model_valid <= 1'b1;
        cyc <= cyc + 1;
    end

    // MAR/MDR registers and SRAM around the WAIT=2 instance
    always @(posedge clk) begin
        if (Reset) begin
            mar         <= 16'h0000;
            mdr         <= 16'h0000;
            sram[8'h10] <= 16'hBEEF;
        end else begin
            if (ld_mar_a) mar <= bus_addr;
            if (ld_mdr_a) mdr <= mdr_sel_a ? sram[mar[7:0]] : bus_data;
            if (!ce_a && !we_a) sram[mar[7:0]] <= mdr;
        end
    end

    // Per-cycle compare against the model plus event bookkeeping
    always @(negedge clk) begin
        if (model_valid) begin
            check("outs_w2", {24'd0, obs_a}, {24'd0, exp_out(m_busy[0], m_phase[0], m_wr[0], 2)});
            check("outs_w15", {24'd0, obs_b}, {24'd0, exp_out(m_busy[1], m_phase[1], m_wr[1], 15)});
            check("oe_we_excl_w2", {31'd0, oe_a | we_a}, 32'd1);
            check("oe_we_excl_w15", {31'd0, oe_b | we_b}, 32'd1);
            if (done_a) begin
                done_cnt[0] <= done_cnt[0] + 1;
                done_cyc[0] <= cyc;
            end
            if (done_b) begin
                done_cnt[1] <= done_cnt[1] + 1;
                done_cyc[1] <= cyc;
            end
            if (ld_mdr_a) ld_mdr_cnt_a <= ld_mdr_cnt_a + 1;
            if (!we_a) we_low_a <= we_low_a + 1;
        end
    end

    task automatic drive(input logic r, input logic w, input logic rs);
        @(posedge clk);
        #1;
        rd_req = r;
        wr_req = w;
        Reset  = rs;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ready_a && ready_b) && n < 60);
        check(name, {31'd0, ready_a & ready_b}, 32'd1);
        @(negedge clk);
    endtask

    task automatic snapshot();
        snap_done_a = done_cnt[0];
        snap_done_b = done_cnt[1];
        snap_ldmdr  = ld_mdr_cnt_a;
        snap_we     = we_low_a;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_phase[i] = 0; m_wr[i] = 0;
            acc_cyc[i] = 0; done_cyc[i] = 0; done_cnt[i] = 0;
        end
        Reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        bus_addr = 16'h0000; bus_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_idle_w2", {24'd0, obs_a}, 32'h87);
        check("reset_idle_w15", {24'd0, obs_b}, 32'h87);

        // Plain read of 0x0010
        snapshot();
        bus_addr = 16'h0010;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wait_idle("rd_complete");
        check("rd_mdr", {16'd0, mdr}, 32'h0000BEEF);
        check("rd_lat_w2", done_cyc[0] - acc_cyc[0], 32'd5);
        check("rd_lat_w15", done_cyc[1] - acc_cyc[1], 32'd18);
        check("rd_done_once", done_cnt[0] - snap_done_a, 32'd1);

        // Write 0x1234 to 0x0042
        snapshot();
        bus_addr = 16'h0042; bus_data = 16'h1234;
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wait_idle("wr_complete");
        check("wr_sram", {16'd0, sram[8'h42]}, 32'h00001234);
        check("wr_lat_w2", done_cyc[0] - acc_cyc[0], 32'd5);
        check("wr_we_cycles", we_low_a - snap_we, 32'd2);

        // Simultaneous read and write: read only
        snapshot();
        bus_addr = 16'h0010; bus_data = 16'h5555;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wait_idle("both_complete");
        check("both_mdr", {16'd0, mdr}, 32'h0000BEEF);
        check("both_we_never", we_low_a - snap_we, 32'd0);
        check("both_done_once", done_cnt[0] - snap_done_a, 32'd1);

        // Reset in the second RD_WAIT cycle
        snapshot();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_mid_idle", {24'd0, obs_a}, 32'h87);
        repeat (8) @(negedge clk);
        wait_idle("rst_recover");
        check("rst_no_done", done_cnt[0] - snap_done_a, 32'd0);
        check("rst_no_ldmdr", ld_mdr_cnt_a - snap_ldmdr, 32'd0);

        // Write request pulsed during a busy read is ignored
        snapshot();
        bus_addr = 16'h0010;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        wait_idle("busy_complete");
        repeat (5) @(negedge clk);
        check("busy_lat_w15", done_cyc[1] - acc_cyc[1], 32'd18);
        check("busy_done_w15", done_cnt[1] - snap_done_b, 32'd1);
        check("busy_done_w2", done_cnt[0] - snap_done_a, 32'd1);
        check("busy_no_write", we_low_a - snap_we, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
